// File: rtl/add16_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : add16_seq_ctrl_if
// Description : Request/result bundle for the nibble-serial 16-bit adder.
//               master drives the request and sees the status/result;
//               slave (the adder) sees the request and drives status/result.
// Signals     : start  - request a new operation (taken only while ready=1)
//               sub    - 0 = A+B, 1 = A-B, captured with start
//               a, b   - 16-bit operands, captured with start
//               ready  - idle and able to accept start
//               busy   - nibble operations in progress
//               done   - one-cycle pulse marking a valid result
//               sum    - 16-bit result word
//               cout   - carry out of bit 15 (subtract: 1 = no borrow)
//               ovf    - two's-complement signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
interface add16_seq_ctrl_if;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  modport master (
    output start,
    output sub,
    output a,
    output b,
    input  ready,
    input  busy,
    input  done,
    input  sum,
    input  cout,
    input  ovf
  );

  modport slave (
    input  start,
    input  sub,
    input  a,
    input  b,
    output ready,
    output busy,
    output done,
    output sum,
    output cout,
    output ovf
  );
endinterface
`default_nettype wire

// File: rtl/add16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fulladd4bit
// Description : 4-bit ripple-carry adder slice built from four full adders.
// Ports       : a_i[3:0], b_i[3:0] - addends
//               c_i                - carry in
//               s_o[3:0]           - sum
//               c_o                - carry out of bit 3
// Revision    : 1.0 - initial release
// ============================================================================
module fulladd4bit (
  input  wire logic [3:0] a_i,
  input  wire logic [3:0] b_i,
  input  wire logic       c_i,
  output logic      [3:0] s_o,
  output logic            c_o
);

  // w_c[k] is the carry into bit k; w_c[4] leaves the slice.
  logic [4:0] w_c;

  assign w_c[0] = c_i;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_bit
      assign s_o[k]   = a_i[k] ^ b_i[k] ^ w_c[k];
      assign w_c[k+1] = (a_i[k] & b_i[k]) | (w_c[k] & (a_i[k] ^ b_i[k]));
    end
  endgenerate

  assign c_o = w_c[4];

endmodule

// ============================================================================
// Module      : add16_seq_ctrl
// Description : 16-bit add/subtract computed nibble-serially on a single
//               fulladd4bit slice, least-significant nibble first.
//               IDLE -> RUN (4 cycles) -> DONE (1 cycle) -> IDLE.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous, active-high reset
//               bus  - add16_seq_ctrl_if.slave (start/sub/a/b in,
//                      ready/busy/done/sum/cout/ovf out)
// Revision    : 1.0 - initial release
// ============================================================================
module add16_seq_ctrl (
  input  wire logic         clk,
  input  wire logic         rst,
  add16_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  idx_q;     // nibble currently being processed
  logic        carry_q;   // carry into the current nibble
  logic [15:0] opa_q;
  logic [15:0] opb_q;     // already inverted for subtract
  logic [15:0] sum_q;
  logic        cout_q;
  logic        ovf_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;

  // Slice inputs are the selected nibble of each captured operand.
  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;
  logic [3:0]  w_nib_s;
  logic        w_nib_c;
  logic [4:0]  w_base;

  assign w_base  = {1'b0, idx_q, 2'b00};
  assign w_nib_a = opa_q[w_base +: 4];
  assign w_nib_b = opb_q[w_base +: 4];

  fulladd4bit u_slice (
    .a_i (w_nib_a),
    .b_i (w_nib_b),
    .c_i (carry_q),
    .s_o (w_nib_s),
    .c_o (w_nib_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      opa_q   <= 16'h0000;
      opb_q   <= 16'h0000;
      sum_q   <= 16'h0000;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Subtract is A + ~B + 1: invert B here and seed carry with 1.
            opa_q   <= bus.a;
            opb_q   <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            idx_q   <= 2'd0;
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end

        RUN: begin
          sum_q[w_base +: 4] <= w_nib_s;
          carry_q            <= w_nib_c;
          idx_q              <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Final carry leaves through cout only; it never feeds bit 0.
            cout_q  <= w_nib_c;
            // w_nib_s[3] is the new sum[15].
            ovf_q   <= (opa_q[15] == opb_q[15]) && (w_nib_s[3] != opa_q[15]);
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_add16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_add16_seq_ctrl
// Description : Directed self-checking bench for add16_seq_ctrl. Inputs are
//               driven and outputs sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add16_seq_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  add16_seq_ctrl_if ifc ();

  add16_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, result, pulse width and return to IDLE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int cnt;
    bit seen;
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = a; ifc.b = b; ifc.sub = sub;
    @(negedge clk);                       // start edge has passed
    ifc.start = 1'b0;
    check({tag, "_busy"}, {31'd0, ifc.busy}, 32'd1);
    seen = 1'b0;
    cnt  = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ifc.done) begin
        cnt  = n;
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_lat"}, cnt, 4);
    if (seen) begin
      check({tag, "_sum"},  {16'd0, ifc.sum}, {16'd0, exp_sum});
      check({tag, "_cout"}, {31'd0, ifc.cout}, {31'd0, exp_cout});
      check({tag, "_ovf"},  {31'd0, ifc.ovf},  {31'd0, exp_ovf});
      @(negedge clk);
      check({tag, "_done1"}, {31'd0, ifc.done},  32'd0);
      check({tag, "_rdy"},   {31'd0, ifc.ready}, 32'd1);
    end
  endtask

  initial begin
    int dcnt;
    logic [15:0] first_sum;
    tests = 0; fails = 0;
    rst = 1'b1;
    ifc.start = 1'b0; ifc.sub = 1'b0; ifc.a = 16'h0; ifc.b = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", {31'd0, ifc.ready}, 32'd1);
    check("rst_busy",  {31'd0, ifc.busy},  32'd0);
    check("rst_done",  {31'd0, ifc.done},  32'd0);
    check("rst_sum",   {16'd0, ifc.sum},   32'h0);
    check("rst_cout",  {31'd0, ifc.cout},  32'd0);
    check("rst_ovf",   {31'd0, ifc.ovf},   32'd0);

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Idle hold: operand changes without start must not disturb the result.
    ifc.a = 16'hAAAA; ifc.b = 16'h5555; ifc.sub = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_sum",   {16'd0, ifc.sum},   32'h5555);
    check("hold_ready", {31'd0, ifc.ready}, 32'd1);

    run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_zero",   16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("add_negneg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("add_mix",    16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // start during RUN with new operands is ignored; exactly one done pulse.
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 16'h1234; ifc.b = 16'h4321; ifc.sub = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0; ifc.a = 16'hFFFF; ifc.b = 16'hFFFF; ifc.sub = 1'b1;
    @(negedge clk);
    ifc.start = 1'b1;
    dcnt = 0;
    first_sum = 16'h0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      ifc.start = 1'b0;
      if (ifc.done) begin
        dcnt++;
        first_sum = ifc.sum;
      end
    end
    ifc.start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (ifc.done) begin
        dcnt++;
        first_sum = ifc.sum;
      end
    end
    check("ign_sum",   {16'd0, first_sum}, 32'h5555);
    check("ign_ndone", dcnt, 1);

    // rst in the second RUN cycle aborts with no done pulse.
    @(negedge clk);
    ifc.start = 1'b1; ifc.a = 16'h7777; ifc.b = 16'h1111; ifc.sub = 1'b0;
    @(negedge clk);
    ifc.start = 1'b0;                     // first RUN cycle
    @(negedge clk);
    rst = 1'b1;                           // second RUN cycle
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, ifc.ready}, 32'd1);
    check("abort_busy",  {31'd0, ifc.busy},  32'd0);
    check("abort_sum",   {16'd0, ifc.sum},   32'h0);
    check("abort_cout",  {31'd0, ifc.cout},  32'd0);
    dcnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ifc.done) dcnt++;
    end
    check("abort_nodone", dcnt, 0);
    run_op("after_abort", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // rst has priority over start in the same cycle.
    @(negedge clk);
    rst = 1'b1; ifc.start = 1'b1; ifc.a = 16'h1111; ifc.b = 16'h2222;
    @(negedge clk);
    rst = 1'b0; ifc.start = 1'b0;
    check("prio_ready", {31'd0, ifc.ready}, 32'd1);
    check("prio_busy",  {31'd0, ifc.busy},  32'd0);
    check("prio_sum",   {16'd0, ifc.sum},   32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
